// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the rv32 memory-bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_t;

    // Instruction fetches always move a full word.
    localparam logic [3:0] FETCH_SEL = 4'hF;

endpackage

// File: rtl/bus_timeout.sv
// Bus transaction watchdog. Counts cycles without an acknowledge and raises
// a registered expired flag one cycle after the count reaches TIMEOUT-1.
module bus_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Count un-acknowledged cycles; clearing wins over counting.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!nrst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            expired <= en && (count == LIMIT);
            if (en) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory bus between instruction fetch and
// load/store. Each transaction is strobed from registered bus outputs, finished
// by bus_ack or aborted by the timeout watchdog, and answered with a one-cycle
// ready pulse. Define MEM_ARB_FAIR_EN for round-robin priority under
// contention; by default the data requester always wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_sel,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_t state;
    arb_state_t next_state;
    grant_t     last_grant;

    logic data_pending;
    logic pick_data;
    logic grant_data;
    logic grant_fetch;
    logic done;
    logic timed_out;
    logic busy;
    logic expired;

    assign data_pending = d_read | d_write;
    assign busy         = (state != IDLE);

`ifdef MEM_ARB_FAIR_EN
    // Under contention, the requester that was not served last goes first.
    always_comb begin
        pick_data = data_pending;
        if (data_pending && i_req) begin
            pick_data = (last_grant == GRANT_FETCH);
        end
    end
`else
    // Fixed priority: any pending load/store beats a fetch.
    always_comb begin
        pick_data = data_pending;
    end

    // last_grant is still tracked in this build but does not steer the choice.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == GRANT_DATA);
`endif

    // Watchdog runs only while a transaction is outstanding.
    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (!busy),
        .en      (busy && !bus_ack),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, grant and completion decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state  = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        done        = 1'b0;
        timed_out   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_data) begin
                    next_state = DATA;
                    grant_data = 1'b1;
                end else if (i_req) begin
                    next_state  = FETCH;
                    grant_fetch = 1'b1;
                end
            end
            FETCH, DATA: begin
                // An ack coinciding with expiry is a normal completion.
                if (bus_ack) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (expired) begin
                    done       = 1'b1;
                    timed_out  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered bus outputs, ready/err pulses and returned read data.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_sel    <= '0;
            i_ready    <= 1'b0;
            i_rdata    <= '0;
            d_ready    <= 1'b0;
            d_rdata    <= '0;
            err        <= 1'b0;
            last_grant <= GRANT_DATA;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            err     <= 1'b0;
            if (grant_data) begin
                // Simultaneous read and write is treated as a write.
                bus_write <= d_write;
                bus_read  <= !d_write;
                bus_addr  <= d_addr;
                bus_wdata <= d_wdata;
                bus_sel   <= d_sel;
            end else if (grant_fetch) begin
                bus_read  <= 1'b1;
                bus_write <= 1'b0;
                bus_addr  <= i_addr;
                bus_sel   <= FETCH_SEL;
            end else if (done) begin
                bus_read  <= 1'b0;
                bus_write <= 1'b0;
                err       <= timed_out;
                if (state == FETCH) begin
                    i_ready    <= 1'b1;
                    i_rdata    <= timed_out ? '0 : bus_rdata;
                    last_grant <= GRANT_FETCH;
                end else begin
                    d_ready    <= 1'b1;
                    last_grant <= GRANT_DATA;
                    if (!bus_write) begin
                        d_rdata <= timed_out ? '0 : bus_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Honors MEM_ARB_FAIR_EN for the
// contention scenario. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_mem_arbiter;

    logic        clk;
    logic        nrst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        err;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks;
    int failures;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_sel     (d_sel),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .err       (err),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (bus_read !== 1'b0 || bus_write !== 1'b0) begin failures++; $display("FAIL reset_strobes rd=%b wr=%b exp=0/0", bus_read, bus_write); end
        checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_pulses i=%b d=%b err=%b exp=0", i_ready, d_ready, err); end
        checks++; if (bus_addr !== 32'h0 || bus_sel !== 4'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_data addr=%h sel=%h ird=%h drd=%h exp=0", bus_addr, bus_sel, i_rdata, d_rdata); end
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 32'h0000_0040;
        step();
        checks++; if (bus_read !== 1'b1 || bus_write !== 1'b0 || bus_sel !== 4'hF || bus_addr !== 32'h0000_0040) begin failures++; $display("FAIL fetch_strobe rd=%b wr=%b sel=%h addr=%h exp=1/0/f/00000040", bus_read, bus_write, bus_sel, bus_addr); end
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++; if (bus_read !== 1'b1 || i_ready !== 1'b0) begin failures++; $display("FAIL fetch_wait%0d rd=%b i_ready=%b exp=1/0", k, bus_read, i_ready); end
        end
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0000_0093;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        checks++; if (i_ready !== 1'b1 || i_rdata !== 32'h0000_0093 || err !== 1'b0 || d_ready !== 1'b0) begin failures++; $display("FAIL fetch_ready i_ready=%b i_rdata=%h err=%b d_ready=%b exp=1/00000093/0/0", i_ready, i_rdata, err, d_ready); end
        checks++; if (bus_read !== 1'b0) begin failures++; $display("FAIL fetch_drop rd=%b exp=0", bus_read); end
        i_req = 1'b0;
        step();
        checks++; if (i_ready !== 1'b0 || i_rdata !== 32'h0000_0093 || bus_read !== 1'b0) begin failures++; $display("FAIL fetch_after i_ready=%b i_rdata=%h rd=%b exp=0/00000093/0", i_ready, i_rdata, bus_read); end
    endtask

    task automatic test_store();
        d_write = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF; d_sel = 4'b0011;
        step();
        checks++; if (bus_write !== 1'b1 || bus_read !== 1'b0 || bus_addr !== 32'h0000_1000 || bus_wdata !== 32'hDEAD_BEEF || bus_sel !== 4'b0011) begin failures++; $display("FAIL store_strobe wr=%b rd=%b addr=%h wdata=%h sel=%b exp=1/0/00001000/deadbeef/0011", bus_write, bus_read, bus_addr, bus_wdata, bus_sel); end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0 || err !== 1'b0 || bus_write !== 1'b0) begin failures++; $display("FAIL store_ready d_ready=%b i_ready=%b err=%b wr=%b exp=1/0/0/0", d_ready, i_ready, err, bus_write); end
        d_write = 1'b0;
        step();
        checks++; if (d_ready !== 1'b0 || i_ready !== 1'b0 || bus_write !== 1'b0 || bus_read !== 1'b0) begin failures++; $display("FAIL store_after d_ready=%b i_ready=%b wr=%b rd=%b exp=0", d_ready, i_ready, bus_write, bus_read); end
    endtask

    task automatic test_load();
        d_read = 1'b1; d_addr = 32'h0000_2004; d_sel = 4'b1100;
        step();
        checks++; if (bus_read !== 1'b1 || bus_write !== 1'b0 || bus_addr !== 32'h0000_2004 || bus_sel !== 4'b1100) begin failures++; $display("FAIL load_strobe rd=%b wr=%b addr=%h sel=%b exp=1/0/00002004/1100", bus_read, bus_write, bus_addr, bus_sel); end
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        checks++; if (d_ready !== 1'b1 || d_rdata !== 32'h1234_5678 || err !== 1'b0) begin failures++; $display("FAIL load_ready d_ready=%b d_rdata=%h err=%b exp=1/12345678/0", d_ready, d_rdata, err); end
        d_read = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic        exp_rd1, exp_wr1, exp_rd2, exp_wr2;
        logic [31:0] exp_addr1, exp_addr2;
`ifdef MEM_ARB_FAIR_EN
        // Previous grant was DATA, so the fetch wins first.
        exp_rd1 = 1'b1; exp_wr1 = 1'b0; exp_addr1 = 32'h0000_0080;
        exp_rd2 = 1'b0; exp_wr2 = 1'b1; exp_addr2 = 32'h0000_3000;
`else
        exp_rd1 = 1'b0; exp_wr1 = 1'b1; exp_addr1 = 32'h0000_3000;
        exp_rd2 = 1'b1; exp_wr2 = 1'b0; exp_addr2 = 32'h0000_0080;
`endif
        i_req = 1'b1; i_addr = 32'h0000_0080;
        d_write = 1'b1; d_addr = 32'h0000_3000; d_wdata = 32'h0000_00AA; d_sel = 4'hF;
        step();
        checks++; if (bus_read !== exp_rd1 || bus_write !== exp_wr1 || bus_addr !== exp_addr1) begin failures++; $display("FAIL cont_first rd=%b wr=%b addr=%h exp=%b/%b/%h", bus_read, bus_write, bus_addr, exp_rd1, exp_wr1, exp_addr1); end
        bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        checks++; if (i_ready !== exp_rd1 || d_ready !== exp_wr1) begin failures++; $display("FAIL cont_ready1 i_ready=%b d_ready=%b exp=%b/%b", i_ready, d_ready, exp_rd1, exp_wr1); end
        checks++; if (bus_read !== 1'b0 || bus_write !== 1'b0) begin failures++; $display("FAIL cont_idle_gap rd=%b wr=%b exp=0/0", bus_read, bus_write); end
        if (exp_rd1) i_req = 1'b0; else d_write = 1'b0;
        step();
        checks++; if (bus_read !== exp_rd2 || bus_write !== exp_wr2 || bus_addr !== exp_addr2) begin failures++; $display("FAIL cont_second rd=%b wr=%b addr=%h exp=%b/%b/%h", bus_read, bus_write, bus_addr, exp_rd2, exp_wr2, exp_addr2); end
        bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        checks++; if (i_ready !== exp_rd2 || d_ready !== exp_wr2 || bus_read !== 1'b0 || bus_write !== 1'b0) begin failures++; $display("FAIL cont_ready2 i_ready=%b d_ready=%b rd=%b wr=%b exp=%b/%b/0/0", i_ready, d_ready, bus_read, bus_write, exp_rd2, exp_wr2); end
        checks++; if (i_rdata !== 32'h0000_0013) begin failures++; $display("FAIL cont_irdata i_rdata=%h exp=00000013", i_rdata); end
        i_req = 1'b0; d_write = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        d_read = 1'b1; d_addr = 32'h0000_4000; d_sel = 4'hF;
        step();
        checks++; if (bus_read !== 1'b1) begin failures++; $display("FAIL to_strobe rd=%b exp=1", bus_read); end
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++; if (d_ready !== 1'b0 || err !== 1'b0 || bus_read !== 1'b1) begin failures++; $display("FAIL to_wait%0d d_ready=%b err=%b rd=%b exp=0/0/1", k, d_ready, err, bus_read); end
        end
        step();
        checks++; if (d_ready !== 1'b1 || err !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL to_abort d_ready=%b err=%b d_rdata=%h exp=1/1/00000000", d_ready, err, d_rdata); end
        checks++; if (bus_read !== 1'b0 || i_ready !== 1'b0) begin failures++; $display("FAIL to_drop rd=%b i_ready=%b exp=0/0", bus_read, i_ready); end
        d_read = 1'b0;
        step();
        checks++; if (d_ready !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL to_pulse_len d_ready=%b err=%b exp=0/0", d_ready, err); end
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        checks++; if (d_ready !== 1'b0 || i_ready !== 1'b0 || err !== 1'b0 || d_rdata !== 32'h0) begin failures++; $display("FAIL late_ack d_ready=%b i_ready=%b err=%b d_rdata=%h exp=0/0/0/0", d_ready, i_ready, err, d_rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        i_req = 1'b1; i_addr = 32'h0000_0100;
        step();
        checks++; if (bus_read !== 1'b1 || bus_addr !== 32'h0000_0100) begin failures++; $display("FAIL rst_pre rd=%b addr=%h exp=1/00000100", bus_read, bus_addr); end
        #2 nrst = 1'b0;
        #1;
        checks++; if (bus_read !== 1'b0 || bus_addr !== 32'h0 || bus_sel !== 4'h0 || i_rdata !== 32'h0) begin failures++; $display("FAIL rst_async rd=%b addr=%h sel=%h i_rdata=%h exp=0", bus_read, bus_addr, bus_sel, i_rdata); end
        step();
        nrst = 1'b1;
        checks++; if (bus_read !== 1'b0 || i_ready !== 1'b0) begin failures++; $display("FAIL rst_release rd=%b i_ready=%b exp=0/0", bus_read, i_ready); end
        step();
        checks++; if (bus_read !== 1'b1 || bus_addr !== 32'h0000_0100 || bus_sel !== 4'hF) begin failures++; $display("FAIL rst_reissue rd=%b addr=%h sel=%h exp=1/00000100/f", bus_read, bus_addr, bus_sel); end
        bus_ack = 1'b1; bus_rdata = 32'h0000_0517;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        checks++; if (i_ready !== 1'b1 || i_rdata !== 32'h0000_0517) begin failures++; $display("FAIL rst_complete i_ready=%b i_rdata=%h exp=1/00000517", i_ready, i_rdata); end
        i_req = 1'b0;
        step();
    endtask

    initial begin
        checks = 0; failures = 0;
        nrst = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        step();
        step();
        test_reset();
        nrst = 1'b1;
        step();
        test_fetch();
        test_store();
        test_load();
        test_contention();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
